// File: rtl/tnaf_pkg.sv
// tnaf_pkg: definitions shared by the tau-NAF word accumulator and its slice.
//   - command encodings for the 3-bit op field (101..111 are no-ops)
//   - controller state enum
//   - tau-NAF digit encodings and the digit helper
package tnaf_pkg;

    localparam logic [2:0] OP_LOAD  = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_SUB   = 3'b010;
    localparam logic [2:0] OP_SHR1  = 3'b011;
    localparam logic [2:0] OP_STORE = 3'b100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_RUN   = 2'd2,
        ST_FIN   = 2'd3
    } state_t;

    localparam logic [1:0] DIG_ZERO = 2'b00;
    localparam logic [1:0] DIG_POS  = 2'b01;
    localparam logic [1:0] DIG_NEG  = 2'b11;

    // Commands that stream an operand in from RAM and need a FETCH cycle.
    function automatic logic is_mem_op(input logic [2:0] op_code);
        return (op_code == OP_LOAD) || (op_code == OP_ADD) || (op_code == OP_SUB);
    endfunction

    // Digit from the two low accumulator bits. Subtracting 2*r1 modulo 4 only
    // flips bit 1, so t = {acc[1]^r1, acc[0]}; t=1 -> +1, t=3 -> -1.
    function automatic logic [1:0] tnaf_digit(input logic [1:0] low_bits, input logic r1);
        if (!low_bits[0])
            return DIG_ZERO;
        return (low_bits[1] ^ r1) ? DIG_NEG : DIG_POS;
    endfunction

endpackage

// File: rtl/tnaf_word_addsub.sv
// tnaf_word_addsub: one W-bit add/subtract slice of the word-serial datapath.
// Ports:
//   a, b   : operand words (b is inverted when sub=1)
//   sub    : 1 selects a + ~b + cin
//   cin    : carry from the previous word
//   sum    : result word
//   cout   : carry out of the MSB
//   c_msb  : carry into the MSB (XOR with cout gives signed overflow)
module tnaf_word_addsub #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         c_msb
);

    logic [W-1:0] b_eff;
    logic [W:0]   full;

    assign b_eff = sub ? ~b : b;
    assign full  = {1'b0, a} + {1'b0, b_eff} + {{W{1'b0}}, cin};
    assign sum   = full[W-1:0];
    assign cout  = full[W];
    // The sum bit at the MSB is a^b^carry_in, so the carry in is recovered
    // without a second adder.
    assign c_msb = a[W-1] ^ b_eff[W-1] ^ full[W-1];

endmodule

// File: rtl/tnaf_word_acc.sv
// tnaf_word_acc: word-serial NWORDS x W-bit two's-complement accumulator.
// Holds one operand internally and streams a second through a dual-port RAM,
// one word per cycle. Commands: LOAD, ADD, SUB, SHR1 (arithmetic), STORE.
// Ports:
//   clk, rst      : clock, synchronous active-low reset
//   start, op     : command strobe (accepted only in IDLE) and opcode
//   base_addr     : RAM word address of operand word 0, latched on start
//   r1_lsb        : LSB of companion operand r1 for the tau-NAF digit
//   rd_addr/doutb : RAM read port (data one cycle after address)
//   wr_addr/dina/wr_en : RAM write port
//   busy, done    : status; done pulses for one cycle
//   LSB_store, zero, sign, ovf, Tbit_pair : flags, valid in IDLE
// Build option: define TNAF_DIGIT_EN to enable Tbit_pair; otherwise it reads
// 00 and r1_lsb is ignored.
module tnaf_word_acc
    import tnaf_pkg::*;
#(
    parameter int W      = 16,
    parameter int NWORDS = 18,
    parameter int AW     = $clog2(NWORDS) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [2:0]    op,
    input  logic [AW-1:0] base_addr,
    input  logic          r1_lsb,
    output logic [AW-1:0] rd_addr,
    input  logic [W-1:0]  doutb,
    output logic [AW-1:0] wr_addr,
    output logic [W-1:0]  dina,
    output logic          wr_en,
    output logic          busy,
    output logic          done,
    output logic          LSB_store,
    output logic          zero,
    output logic          sign,
    output logic          ovf,
    output logic [1:0]    Tbit_pair
);

    // Word index is one bit wider than needed so index+1 never wraps.
    localparam int            KW     = $clog2(NWORDS) + 1;
    localparam logic [KW-1:0] K_LAST = KW'(NWORDS - 1);

    state_t          state_reg, state_next;
    logic [2:0]      op_reg;
    logic [AW-1:0]   base_reg;
    logic [KW-1:0]   k_reg;
    logic            c_reg;
    logic            ovf_reg;
    logic [W-1:0]    acc_reg [NWORDS];
    logic [AW-1:0]   rd_addr_reg, wr_addr_reg;
    logic [W-1:0]    dina_reg;
    logic            wr_en_reg;

    logic [KW-1:0]   sel_idx;
    logic [W-1:0]    sel_word;
    logic [W-1:0]    new_word;
    logic [W-1:0]    as_sum;
    logic            as_cout, as_cmsb;
    logic            acc_we;
    logic [NWORDS-1:0] word_nz;

    // ---------------- controller ----------------
    always_ff @(posedge clk) begin
        if (!rst)
            state_reg <= ST_IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (is_mem_op(op))
                        state_next = ST_FETCH;
                    else if (op == OP_SHR1 || op == OP_STORE)
                        state_next = ST_RUN;
                    else
                        state_next = ST_FIN;
                end
            end
            ST_FETCH: state_next = ST_RUN;
            ST_RUN:   if (k_reg == K_LAST) state_next = ST_FIN;
            ST_FIN:   state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // ---------------- word selection ----------------
    // SHR1 walks MSW first; STORE prefetches the next word into dina.
    always_comb begin
        sel_idx = k_reg;
        if (op_reg == OP_SHR1)
            sel_idx = K_LAST - k_reg;
        else if (op_reg == OP_STORE)
            sel_idx = k_reg + 1'b1;
    end

    always_comb begin
        sel_word = '0;
        for (int i = 0; i < NWORDS; i++)
            if (sel_idx == KW'(i))
                sel_word = acc_reg[i];
    end

    tnaf_word_addsub #(.W(W)) u_addsub (
        .a     (sel_word),
        .b     (doutb),
        .sub   (op_reg == OP_SUB),
        .cin   (c_reg),
        .sum   (as_sum),
        .cout  (as_cout),
        .c_msb (as_cmsb)
    );

    // In SHR1 c_reg carries the bit dropped off the word above.
    always_comb begin
        new_word = as_sum;
        if (op_reg == OP_LOAD)
            new_word = doutb;
        else if (op_reg == OP_SHR1)
            new_word = {c_reg, sel_word[W-1:1]};
    end

    assign acc_we = (state_reg == ST_RUN) && (op_reg != OP_STORE);

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_reg      <= OP_LOAD;
            base_reg    <= '0;
            k_reg       <= '0;
            c_reg       <= 1'b0;
            ovf_reg     <= 1'b0;
            rd_addr_reg <= '0;
            wr_addr_reg <= '0;
            dina_reg    <= '0;
            wr_en_reg   <= 1'b0;
            for (int i = 0; i < NWORDS; i++)
                acc_reg[i] <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        op_reg   <= op;
                        base_reg <= base_addr;
                        k_reg    <= '0;
                        c_reg    <= (op == OP_SHR1) ? acc_reg[NWORDS-1][W-1] : (op == OP_SUB);
                        if (is_mem_op(op))
                            rd_addr_reg <= base_addr;
                        if (op == OP_STORE) begin
                            wr_en_reg   <= 1'b1;
                            wr_addr_reg <= base_addr;
                            dina_reg    <= acc_reg[0];
                        end
                    end
                end
                ST_FETCH: rd_addr_reg <= base_reg + AW'(1);
                ST_RUN: begin
                    k_reg <= k_reg + 1'b1;
                    if (is_mem_op(op_reg))
                        rd_addr_reg <= base_reg + AW'(k_reg) + AW'(2);
                    case (op_reg)
                        OP_ADD, OP_SUB: begin
                            c_reg <= as_cout;
                            if (k_reg == K_LAST)
                                ovf_reg <= as_cmsb ^ as_cout;
                        end
                        OP_SHR1: c_reg <= sel_word[0];
                        OP_STORE: begin
                            if (k_reg == K_LAST) begin
                                wr_en_reg <= 1'b0;
                            end else begin
                                wr_addr_reg <= base_reg + AW'(k_reg) + AW'(1);
                                dina_reg    <= sel_word;
                            end
                        end
                        default: ;
                    endcase
                    if (acc_we)
                        for (int i = 0; i < NWORDS; i++)
                            if (sel_idx == KW'(i))
                                acc_reg[i] <= new_word;
                end
                default: ;
            endcase
        end
    end

    // ---------------- outputs and flags ----------------
    assign busy    = (state_reg != ST_IDLE);
    assign done    = (state_reg == ST_FIN);
    assign rd_addr = rd_addr_reg;
    assign wr_addr = wr_addr_reg;
    assign dina    = dina_reg;
    assign wr_en   = wr_en_reg;
    assign ovf     = ovf_reg;

    generate
        for (genvar gi = 0; gi < NWORDS; gi++) begin : g_nz
            assign word_nz[gi] = |acc_reg[gi];
        end
    endgenerate

    assign zero      = ~|word_nz;
    assign sign      = acc_reg[NWORDS-1][W-1];
    assign LSB_store = acc_reg[0][0];

`ifdef TNAF_DIGIT_EN
    assign Tbit_pair = tnaf_digit(acc_reg[0][1:0], r1_lsb);
`else
    logic unused_r1_lsb;
    assign unused_r1_lsb = r1_lsb;
    assign Tbit_pair     = DIG_ZERO;
`endif

endmodule

// File: tb/tb_tnaf_word_acc.sv
// Bench for tnaf_word_acc at W=16, NWORDS=4. A behavioural RAM feeds the DUT;
// a 64-bit model of the accumulator predicts flags, latency and STORE writes.
// Expected writes are queued when a STORE is issued and popped by a monitor.
module tb_tnaf_word_acc;
    import tnaf_pkg::*;

    localparam int W  = 16;
    localparam int N  = 4;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    op = 3'b000;
    logic [AW-1:0] base_addr = '0;
    logic          r1_lsb = 1'b0;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [W-1:0]  doutb, dina;
    logic          wr_en, busy, done, LSB_store, zero, sign, ovf;
    logic [1:0]    Tbit_pair;

    logic [W-1:0]  ram [2**AW];

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
    } wr_t;
    wr_t exp_wq[$];

    logic [63:0] acc_m;
    logic        ovf_m;
    int          n_total = 0;
    int          n_bad   = 0;

    always #5 clk = ~clk;

    tnaf_word_acc #(.W(W), .NWORDS(N), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .op        (op),
        .base_addr (base_addr),
        .r1_lsb    (r1_lsb),
        .rd_addr   (rd_addr),
        .doutb     (doutb),
        .wr_addr   (wr_addr),
        .dina      (dina),
        .wr_en     (wr_en),
        .busy      (busy),
        .done      (done),
        .LSB_store (LSB_store),
        .zero      (zero),
        .sign      (sign),
        .ovf       (ovf),
        .Tbit_pair (Tbit_pair)
    );

    // Dual-port RAM: registered read, one-cycle latency.
    always @(posedge clk) begin
        if (wr_en)
            ram[wr_addr] = dina;
        doutb <= ram[rd_addr];
    end

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every wr_en cycle must match the head of the queue.
    always @(negedge clk) begin
        if (wr_en) begin
            if (exp_wq.size() == 0) begin
                chk_eq("wr_extra", 64'(wr_en), 64'd0);
            end else begin
                wr_t e;
                e = exp_wq.pop_front();
                chk_eq("wr_addr", 64'(wr_addr), 64'(e.addr));
                chk_eq("wr_data", 64'(dina), 64'(e.data));
            end
        end
    end

    task automatic put64(input logic [AW-1:0] b, input logic [63:0] v);
        for (int i = 0; i < N; i++)
            ram[AW'(int'(b) + i)] = v[16*i +: 16];
    endtask

    function automatic logic [63:0] get64(input logic [AW-1:0] b);
        logic [63:0] v;
        for (int i = 0; i < N; i++)
            v[16*i +: 16] = ram[AW'(int'(b) + i)];
        return v;
    endfunction

    function automatic logic [1:0] exp_digit();
`ifdef TNAF_DIGIT_EN
        int t;
        if (!acc_m[0])
            return 2'b00;
        t = (int'(acc_m[1:0]) - 2 * int'(r1_lsb) + 4) % 4;
        return (t == 1) ? 2'b01 : 2'b11;
`else
        return 2'b00;
`endif
    endfunction

    // Issue one command, predict its effect, wait for done and check flags.
    // mid_start pulses start during busy; done_start pulses it on the done cycle.
    task automatic run_cmd(input logic [2:0] c_op, input logic [AW-1:0] b,
                           input bit mid_start, input bit done_start);
        logic [63:0] m, s;
        int exp_lat, lat;
        m = get64(b);
        s = '0;
        case (c_op)
            3'b000: begin acc_m = m; exp_lat = N + 2; end
            3'b001: begin
                s = acc_m + m;
                ovf_m = (acc_m[63] == m[63]) && (s[63] != acc_m[63]);
                acc_m = s; exp_lat = N + 2;
            end
            3'b010: begin
                s = acc_m - m;
                ovf_m = (acc_m[63] != m[63]) && (s[63] != acc_m[63]);
                acc_m = s; exp_lat = N + 2;
            end
            3'b011: begin acc_m = {acc_m[63], acc_m[63:1]}; exp_lat = N + 1; end
            3'b100: begin
                for (int i = 0; i < N; i++)
                    exp_wq.push_back('{addr: AW'(int'(b) + i), data: acc_m[16*i +: 16]});
                exp_lat = N + 1;
            end
            default: exp_lat = 1;
        endcase
        op = c_op; base_addr = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 1;
        while (!done && lat < 40) begin
            if (mid_start && lat == 2) begin
                start = 1'b1; op = 3'b100;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        chk_eq("latency", 64'(lat), 64'(exp_lat));
        $display("cmd op=%0d base=%0d latency=%0d acc_model=%016h", c_op, b, lat, acc_m);
        if (done_start) begin
            start = 1'b1; op = 3'b100; base_addr = b;
        end
        @(posedge clk); #1;
        start = 1'b0;
        chk_eq("busy_idle", 64'(busy), 64'd0);
        chk_eq("done_low",  64'(done), 64'd0);
        chk_eq("sign",      64'(sign), 64'(acc_m[63]));
        chk_eq("zero",      64'(zero), 64'(acc_m == 64'd0));
        chk_eq("lsb",       64'(LSB_store), 64'(acc_m[0]));
        chk_eq("ovf",       64'(ovf), 64'(ovf_m));
        chk_eq("tbit",      64'(Tbit_pair), 64'(exp_digit()));
    endtask

    initial begin
        for (int i = 0; i < 2**AW; i++)
            ram[i] = '0;
        acc_m = '0;
        ovf_m = 1'b0;

        // Reset values
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_eq("rst_busy",  64'(busy), 64'd0);
        chk_eq("rst_done",  64'(done), 64'd0);
        chk_eq("rst_wr_en", 64'(wr_en), 64'd0);
        chk_eq("rst_rd_addr", 64'(rd_addr), 64'd0);
        chk_eq("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk_eq("rst_dina",  64'(dina), 64'd0);
        chk_eq("rst_zero",  64'(zero), 64'd1);
        chk_eq("rst_sign",  64'(sign), 64'd0);
        chk_eq("rst_lsb",   64'(LSB_store), 64'd0);
        chk_eq("rst_ovf",   64'(ovf), 64'd0);
        chk_eq("rst_tbit",  64'(Tbit_pair), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;

        // LOAD then STORE
        put64(0, 64'h8000_0000_0000_0001);
        run_cmd(OP_LOAD, 0, 0, 0);
        run_cmd(OP_STORE, 4, 0, 0);
        chk_eq("load_readback", get64(4), 64'h8000_0000_0000_0001);

        // ADD carry chain
        put64(0, 64'h0000_0000_0000_FFFF);
        put64(4, 64'h0000_0000_0000_0001);
        run_cmd(OP_LOAD, 0, 0, 0);
        run_cmd(OP_ADD, 4, 0, 0);
        run_cmd(OP_STORE, 0, 0, 0);
        chk_eq("add_result", get64(0), 64'h0000_0000_0001_0000);

        // SUB to all-ones, then signed overflow
        put64(0, 64'h0);
        run_cmd(OP_LOAD, 0, 0, 0);
        run_cmd(OP_SUB, 4, 0, 0);
        run_cmd(OP_STORE, 0, 0, 0);
        chk_eq("sub_result", get64(0), 64'hFFFF_FFFF_FFFF_FFFF);
        put64(0, 64'h8000_0000_0000_0000);
        run_cmd(OP_LOAD, 0, 0, 0);
        run_cmd(OP_SUB, 4, 0, 0);
        chk_eq("sub_ovf", 64'(ovf), 64'd1);

        // SHR1 across word boundaries
        put64(0, 64'hFFFF_0000_0000_0003);
        run_cmd(OP_LOAD, 0, 0, 0);
        run_cmd(OP_SHR1, 0, 0, 0);
        run_cmd(OP_STORE, 4, 0, 0);
        chk_eq("shr_result", get64(4), 64'hFFFF_8000_0000_0001);

        // Base address wrapping modulo 2^AW
        put64(6, 64'h0123_4567_89AB_CDEF);
        run_cmd(OP_LOAD, 6, 0, 0);
        run_cmd(OP_ADD, 6, 0, 0);
        run_cmd(OP_STORE, 7, 0, 0);
        chk_eq("wrap_result", get64(7), 64'h0246_8ACF_1357_9BDE);

        // Tau-NAF digit patterns
        r1_lsb = 1'b0; put64(0, 64'h5); run_cmd(OP_LOAD, 0, 0, 0);
        r1_lsb = 1'b0; put64(0, 64'h7); run_cmd(OP_LOAD, 0, 0, 0);
        r1_lsb = 1'b1; put64(0, 64'h5); run_cmd(OP_LOAD, 0, 0, 0);
        r1_lsb = 1'b1; put64(0, 64'h7); run_cmd(OP_LOAD, 0, 0, 0);
        r1_lsb = 1'b1; put64(0, 64'h6); run_cmd(OP_LOAD, 0, 0, 0);
        r1_lsb = 1'b0;

        // start during busy and on the done cycle are ignored
        put64(0, 64'hA5A5_0000_1234_8001);
        run_cmd(OP_LOAD, 0, 1, 1);
        run_cmd(OP_STORE, 4, 1, 1);

        // no-op leaves acc unchanged
        run_cmd(3'b101, 2, 0, 0);
        run_cmd(3'b111, 2, 0, 0);
        run_cmd(OP_STORE, 4, 0, 0);
        chk_eq("noop_readback", get64(4), 64'hA5A5_0000_1234_8001);

        // Reset during STORE RUN cycle 2
        put64(0, 64'h1234_5678_9ABC_DEF1);
        run_cmd(OP_LOAD, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            exp_wq.push_back('{addr: AW'(4 + i), data: acc_m[16*i +: 16]});
        op = OP_STORE; base_addr = 4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        acc_m = '0;
        ovf_m = 1'b0;
        $display("cmd abort store at run cycle 2");
        chk_eq("abort_wr_en", 64'(wr_en), 64'd0);
        chk_eq("abort_busy",  64'(busy), 64'd0);
        chk_eq("abort_zero",  64'(zero), 64'd1);
        @(posedge clk); #1;
        chk_eq("abort_wr_en2", 64'(wr_en), 64'd0);
        run_cmd(OP_STORE, 4, 0, 0);
        chk_eq("abort_readback", get64(4), 64'h0);

        chk_eq("wq_left", 64'(exp_wq.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
